// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, default width.
// MADD/MADDU legality depends on MULTDIV_ACC_EN.
package mips_pkg;

  localparam int SIZE_DEF = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
`ifdef MULTDIV_ACC_EN
    return (op <= OP_MADDU);
`else
    return (op <= OP_DIVU);
`endif
  endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of shift-add multiply or restoring divide on an {acc_hi, acc_lo} pair.
// Latency: purely combinational. Backpressure: none.
// Mode: div_mode_i=0 multiply (acc_lo holds multiplier), 1 divide (acc_lo holds dividend).
module md_step import mips_pkg::*; #(
  parameter int SIZE = SIZE_DEF
) (
  input  logic            div_mode_i,
  input  logic [SIZE-1:0] acc_hi_i,
  input  logic [SIZE-1:0] acc_lo_i,
  input  logic [SIZE-1:0] operand_i,
  output logic [SIZE-1:0] acc_hi_o,
  output logic [SIZE-1:0] acc_lo_o
);

  logic [SIZE:0] sum;
  logic [SIZE:0] rem;
  logic [SIZE:0] diff;

  always_comb begin
    sum  = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, operand_i} : '0);
    rem  = {acc_hi_i, acc_lo_i[SIZE-1]};
    diff = rem - {1'b0, operand_i};
    acc_hi_o = sum[SIZE:1];
    acc_lo_o = {sum[0], acc_lo_i[SIZE-1:1]};
    if (div_mode_i) begin
      // diff[SIZE] is the borrow: set when the partial remainder is below the divisor
      if (!diff[SIZE]) begin
        acc_hi_o = diff[SIZE-1:0];
        acc_lo_o = {acc_lo_i[SIZE-2:0], 1'b1};
      end else begin
        acc_hi_o = rem[SIZE-1:0];
        acc_lo_o = {acc_lo_i[SIZE-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO; MADD/MADDU accumulate when MULTDIV_ACC_EN is defined.
// Latency: SIZE RUN cycles + FIX + DONE; done pulses SIZE+2 edges after start is sampled (inclusive).
// Backpressure: none; start/mthi/mtlo are ignored while busy, caller must watch busy/done.
module mult_div_unit import mips_pkg::*; #(
  parameter int SIZE = SIZE_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [SIZE-1:0] rs_data,
  input  logic [SIZE-1:0] rt_data,
  input  logic            mthi,
  input  logic            mtlo,
  output logic [SIZE-1:0] hi,
  output logic [SIZE-1:0] lo,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SIZE);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] acc_hi_q, acc_hi_d;
  logic [SIZE-1:0] acc_lo_q, acc_lo_d;
  logic [SIZE-1:0] opb_q, opb_d;
  logic [SIZE-1:0] hi_q, hi_d;
  logic [SIZE-1:0] lo_q, lo_d;
  logic            div_q, div_d;
  logic            neg_q, neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic            div0_q, div0_d;
`ifdef MULTDIV_ACC_EN
  logic            acc_q, acc_d;
`endif

  logic            a_neg, b_neg;
  logic [SIZE-1:0] a_mag, b_mag;
  logic [SIZE-1:0] step_hi, step_lo;
  logic [2*SIZE-1:0] prod, prod_fix;
  logic [SIZE-1:0] quo_fix, rem_fix;

  // Signed ops are the even codes; magnitudes of -2^(SIZE-1) stay exact as unsigned SIZE bits
  assign a_neg = ~op[0] & rs_data[SIZE-1];
  assign b_neg = ~op[0] & rt_data[SIZE-1];
  assign a_mag = a_neg ? -rs_data : rs_data;
  assign b_mag = b_neg ? -rt_data : rt_data;

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  // A zero divisor leaves the all-ones quotient untouched regardless of signs
  assign quo_fix  = (neg_q & ~div0_q) ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = rem_neg_q ? -acc_hi_q : acc_hi_q;

  md_step #(.SIZE(SIZE)) u_step (
    .div_mode_i (div_q),
    .acc_hi_i   (acc_hi_q),
    .acc_lo_i   (acc_lo_q),
    .operand_i  (opb_q),
    .acc_hi_o   (step_hi),
    .acc_lo_o   (step_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_d     = div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
`ifdef MULTDIV_ACC_EN
    acc_d     = acc_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start && op_legal(op)) begin
          acc_hi_d  = '0;
          acc_lo_d  = a_mag;
          opb_d     = b_mag;
          div_d     = (op[2:1] == 2'b01);
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          div0_d    = (rt_data == '0);
`ifdef MULTDIV_ACC_EN
          acc_d     = op[2];
`endif
          cnt_d     = CNT_INIT;
          state_d   = ST_RUN;
        end else begin
          if (mthi) hi_d = rs_data;
          if (mtlo) lo_d = rs_data;
        end
      end
      ST_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
`ifdef MULTDIV_ACC_EN
          if (acc_q) {hi_d, lo_d} = {hi_q, lo_q} + prod_fix;
          else       {hi_d, lo_d} = prod_fix;
`else
          {hi_d, lo_d} = prod_fix;
`endif
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
`ifdef MULTDIV_ACC_EN
      acc_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
`ifdef MULTDIV_ACC_EN
      acc_q     <= acc_d;
`endif
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against an arithmetic HI/LO model.
// MADD/MADDU expectations follow MULTDIV_ACC_EN.
module tb_mult_div_unit;

  localparam int SIZE = 32;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            start;
  logic [2:0]      op;
  logic [SIZE-1:0] rs_data, rt_data;
  logic            mthi, mtlo;
  logic [SIZE-1:0] hi, lo;
  logic            busy, done;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clock = ~clock;

  mult_div_unit #(.SIZE(SIZE)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit legal_op(input logic [2:0] o);
`ifdef MULTDIV_ACC_EN
    return o <= 3'd5;
`else
    return o <= 3'd3;
`endif
  endfunction

  // Expected {HI,LO} after op, from plain 64-bit arithmetic on the current model state
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = {m_hi, m_lo};
    case (o)
      3'd0: p = 64'(sa * sb);
      3'd1: p = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      3'd3: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
`ifdef MULTDIV_ACC_EN
      3'd4: p = {m_hi, m_lo} + 64'(sa * sb);
      3'd5: p = {m_hi, m_lo} + {32'd0, a} * {32'd0, b};
`endif
      default: p = {m_hi, m_lo};
    endcase
    return p;
  endfunction

  task automatic move(input bit to_hi, input bit to_lo, input logic [31:0] v);
    @(negedge clock);
    mthi = to_hi; mtlo = to_lo; rs_data = v;
    @(posedge clock);
    #1;
    mthi = 1'b0; mtlo = 1'b0;
    if (to_hi) m_hi = v;
    if (to_lo) m_lo = v;
    chk("move", {hi, lo}, {m_hi, m_lo});
  endtask

  // poke: mid-operation start+mtlo that must be ignored; with_mthi: move alongside start
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit poke, input bit with_mthi);
    logic [63:0] exp;
    int  edges;
    bit  seen;
    exp = model(o, a, b);
    @(negedge clock);
    start = 1'b1; op = o; rs_data = a; rt_data = b; mthi = with_mthi;
    @(posedge clock);
    edges = 1;
    #1;
    start = 1'b0; mthi = 1'b0;
    if (with_mthi) chk({tag, "_mthi_drop"}, 64'(hi), 64'(m_hi));
    if (legal_op(o)) begin
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(posedge clock);
        edges++;
        #1;
        start = 1'b0; mtlo = 1'b0;
        if (poke && i == 4) begin
          start = 1'b1; op = 3'd0; mtlo = 1'b1; rs_data = 32'h1234;
        end
        if (i == 10) chk({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      chk({tag, "_seen"}, 64'(seen), 64'd1);
      chk({tag, "_lat"}, 64'(edges), 64'(SIZE + 2));
      chk({tag, "_res"}, {hi, lo}, exp);
      chk({tag, "_busy_done"}, 64'(busy), 64'd0);
      @(posedge clock);
      #1;
      chk({tag, "_pulse"}, 64'(done), 64'd0);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end else begin
      chk({tag, "_ill_busy"}, 64'(busy), 64'd0);
      seen = 1'b0;
      for (int i = 0; i < SIZE + 4; i++) begin
        @(posedge clock);
        #1;
        if (done || busy) seen = 1'b1;
      end
      chk({tag, "_ill_quiet"}, 64'(seen), 64'd0);
      chk({tag, "_ill_res"}, {hi, lo}, {m_hi, m_lo});
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    reset_n = 1'b0; start = 1'b0; op = '0; rs_data = '0; rt_data = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op("divu", 3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op("divu_z", 3'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op("div_z_neg", 3'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("interlock", 3'd3, 32'd1000, 32'd7, 1'b1, 1'b0);
    run_op("start_mthi", 3'd1, 32'hDEAD_0001, 32'd3, 1'b0, 1'b1);
    move(1'b1, 1'b0, 32'hAAAA_0000);
    move(1'b1, 1'b1, 32'h5555_1234);
    move(1'b1, 1'b0, 32'd0);
    move(1'b0, 1'b1, 32'd10);
    run_op("madd", 3'd4, 32'd3, 32'd4, 1'b0, 1'b0);
    run_op("maddu", 3'd5, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    run_op("illegal6", 3'd6, 32'd9, 32'd9, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      logic [2:0] ro;
      ro = 3'($urandom_range(0, 7));
      run_op($sformatf("rnd%0d", n), ro, pick(), pick(), 1'b0, 1'b0);
    end

    // Reset mid-operation
    @(negedge clock);
    start = 1'b1; op = 3'd1; rs_data = 32'd7; rt_data = 32'd9;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_hilo", {hi, lo}, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < SIZE + 8; i++) begin
      @(posedge clock);
      #1;
      if (done || busy) seen = 1'b1;
    end
    chk("arst_quiet", 64'(seen), 64'd0);
    chk("arst_after", {hi, lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
